// File: rtl/rf_fifo_ctrl.sv
// rf_fifo_ctrl: FIFO controller around a 256x26 single-port register-file macro,
// with a one-word input holding register and a small prefetch buffer on the pop side.
module rf_fifo_ctrl #(
   parameter int DW         = 26,
   parameter int AW         = 8,
   parameter int DEPTH      = 256,
   parameter int OB_DEPTH   = 4,
   parameter int INIT_CLEAR = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          m_nce,
   output logic          m_nwrt,
   output logic [AW-3:0] m_ra,
   output logic [1:0]    m_ca,
   output logic [DW-1:0] m_din,
   input  logic [DW-1:0] m_do,
   output logic [AW:0]   level,
   output logic          init_busy
);
   localparam int OW = $clog2(OB_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [OW+1:0] OBD = (OW+2)'(OB_DEPTH);

   typedef enum logic {INIT, RUN} state_t;
   state_t state, state_n;

   logic [AW-1:0] wr_ptr, rd_ptr, addr_n;
   logic          hold_full, hold_full_n;
   logic [DW-1:0] hold_data, din_n, out_data_n;
   logic [1:0]    infl;
   logic [DW-1:0] ob_mem [OB_DEPTH];
   logic [OW-1:0] ob_rd, ob_wr, ob_rd_n;
   logic [OW:0]   ob_cnt, ob_cnt_n, ob_rem;
   logic [OW+1:0] credit;
   logic          push, pop, cap, rd, wr_run, wr;

   always_comb begin
      push = in_valid && in_ready;
      pop = out_valid && out_ready;
      cap = infl[1];
      // words that will sit in the buffer or be in flight once this edge settles
      credit = (OW+2)'(ob_cnt) + (OW+2)'(infl[0]) + (OW+2)'(infl[1]) - (OW+2)'(pop);
      rd = state == RUN && level != '0 && credit < OBD;
      wr_run = state == RUN && !rd && hold_full && level < FULL;
      wr = wr_run || state == INIT;
      state_n = (state == INIT && wr_ptr == '1) ? RUN : state;
      hold_full_n = push || (hold_full && !wr_run);
      addr_n = rd ? rd_ptr : wr ? wr_ptr : {m_ra, m_ca};
      din_n = wr_run ? hold_data : state == INIT ? '0 : m_din;
      ob_rd_n = pop ? ob_rd + 1'b1 : ob_rd;
      ob_rem = ob_cnt - (OW+1)'(pop);
      ob_cnt_n = ob_rem + (OW+1)'(cap);
      out_data_n = ob_rem != '0 ? ob_mem[ob_rd_n] : cap ? m_do : out_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= INIT_CLEAR != 0 ? INIT : RUN;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         hold_full <= 1'b0;
         hold_data <= '0;
         in_ready <= 1'b0;
         m_nce <= 1'b1;
         m_nwrt <= 1'b1;
         {m_ra, m_ca} <= '0;
         m_din <= '0;
         infl <= '0;
         for (int i = 0; i < OB_DEPTH; i++) ob_mem[i] <= '0;
         ob_wr <= '0;
         ob_rd <= '0;
         ob_cnt <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         init_busy <= INIT_CLEAR != 0;
      end else begin
         state <= state_n;
         wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
         level <= wr_run ? level + 1'b1 : rd ? level - 1'b1 : level;
         hold_full <= hold_full_n;
         if (push) hold_data <= in_data;
         in_ready <= state == RUN && !hold_full_n;
         m_nce <= !(rd || wr);
         m_nwrt <= !wr;
         {m_ra, m_ca} <= addr_n;
         m_din <= din_n;
         infl <= {infl[0], rd};
         if (cap) begin
            ob_mem[ob_wr] <= m_do;
            ob_wr <= ob_wr + 1'b1;
         end
         ob_rd <= ob_rd_n;
         ob_cnt <= ob_cnt_n;
         out_valid <= ob_cnt_n != '0;
         out_data <= out_data_n;
         init_busy <= state_n == INIT;
      end
   end
endmodule

// File: tb/tb_rf_fifo_ctrl.sv
// tb_rf_fifo_ctrl: random push/pop traffic against a queue model, with a behavioural
// macro attached to the controller's memory port.
module tb_rf_fifo_ctrl;
   localparam int DW = 26;

   logic          clk = 0, rst = 0, in_valid = 0, out_ready = 0;
   logic          in_ready, out_valid, m_nce, m_nwrt, init_busy;
   logic [DW-1:0] in_data = '0, out_data, m_din, m_do;
   logic [5:0]    m_ra;
   logic [1:0]    m_ca;
   logic [8:0]    level;
   logic [DW-1:0] mem [256];
   logic [DW-1:0] ref_q [$];
   int n_checks = 0, n_fail = 0, cyc = 0, mode = 0, reads = 0, pops = 0, first_ov = -1, acc_cyc = 0;

   rf_fifo_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .m_nce(m_nce), .m_nwrt(m_nwrt), .m_ra(m_ra), .m_ca(m_ca),
      .m_din(m_din), .m_do(m_do), .level(level), .init_busy(init_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // macro: samples the port one edge after it is driven, DO holds the last read
   always @(posedge clk)
      if (!m_nce) begin
         if (!m_nwrt) mem[{m_ra, m_ca}] <= m_din;
         else m_do <= mem[{m_ra, m_ca}];
      end

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic check_reset();
      chk("rst_m_nce", longint'(m_nce), 1);
      chk("rst_m_nwrt", longint'(m_nwrt), 1);
      chk("rst_m_ra", longint'(m_ra), 0);
      chk("rst_m_ca", longint'(m_ca), 0);
      chk("rst_m_din", longint'(m_din), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_level", longint'(level), 0);
      chk("rst_init_busy", longint'(init_busy), 1);
   endtask

   task automatic send(input logic [DW-1:0] v);
      int w = 0;
      in_valid = 1;
      in_data = v;
      while (!in_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (in_ready) begin
         ref_q.push_back(v);
         acc_cyc = cyc + 1;
      end else chk("push_accept", longint'(in_ready), 1);
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic wait_drain(input string name);
      int w = 0;
      while ((ref_q.size() != 0 || out_valid) && w < 4000) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      chk(name, longint'(ref_q.size()), 0);
      chk({name, "_level"}, longint'(level), 0);
   endtask

   // monitor: drives out_ready, pops the model on every handshake, bounds outstanding reads
   initial forever begin
      @(negedge clk);
      if (rst) begin
         reads = 0;
         pops = 0;
      end else begin
         if (!m_nce && m_nwrt) reads++;
         chk("outstanding_le_ob", longint'(reads - pops <= 4), 1);
         out_ready = mode == 1 ? 1'b1 : mode == 2 ? !out_ready : mode == 3 ? 1'($urandom_range(0, 1)) : 1'b0;
         if (out_valid && first_ov < 0) first_ov = cyc;
         if (out_valid && out_ready) begin
            pops++;
            if (ref_q.size() == 0) chk("pop_queue_size", 0, 1);
            else chk("out_data", longint'(out_data), longint'(ref_q.pop_front()));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int busy, nw, last, rise, bad, a0, w, ov;
      #1 rst = 1;
      #2 check_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      busy = 0; nw = 0; last = -1; rise = -1; bad = 0;
      for (int c = 0; c < 300; c++) begin
         if (init_busy) busy++;
         if (!m_nce) begin
            if (m_nwrt || {m_ra, m_ca} != nw[7:0] || m_din != '0) bad++;
            nw++;
            last = c;
         end
         if (in_ready && rise < 0) rise = c;
         @(negedge clk);
      end
      chk("init_busy_cycles", busy, 256);
      chk("init_write_count", nw, 256);
      chk("init_addr_data", bad, 0);
      chk("in_ready_after_init", rise, last + 1);

      first_ov = -1;
      mode = 1;
      send(26'h1234567);
      a0 = acc_cyc;
      send(26'h2ABCDEF);
      send(26'h0000001);
      wait_drain("three_words");
      chk("first_out_latency_ge4", longint'(first_ov - a0 >= 4), 1);

      mode = 0;
      for (int i = 0; i < 261; i++) send(DW'(i));
      w = 0;
      in_valid = 1;
      in_data = DW'(261);
      for (int i = 0; i < 20; i++) begin
         if (in_ready) w++;
         @(negedge clk);
      end
      in_valid = 0;
      chk("full_no_extra_accept", w, 0);
      chk("full_level", longint'(level), 256);
      chk("full_in_ready", longint'(in_ready), 0);
      mode = 1;
      wait_drain("drain_261");

      mode = 3;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         send(DW'($urandom));
      end
      wait_drain("sustained_600");

      mode = 2;
      for (int i = 0; i < 100; i++) send(DW'($urandom));
      wait_drain("toggle_ready");

      mode = 0;
      for (int i = 0; i < 54; i++) send(DW'(i + 1000));
      w = 0;
      while (level != 50 && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk("level_50", longint'(level), 50);
      mode = 1;
      w = 0;
      while (!(!m_nce && m_nwrt) && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("read_in_flight", longint'(!m_nce && m_nwrt), 1);
      #2 rst = 1;
      #1 check_reset();
      ref_q.delete();
      @(negedge clk);
      #2 rst = 0;
      ov = 0;
      for (int i = 0; i < 400 && !in_ready; i++) begin
         @(negedge clk);
         if (out_valid) ov++;
      end
      chk("post_rst_no_capture", ov, 0);
      chk("post_rst_in_ready", longint'(in_ready), 1);
      chk("post_rst_level", longint'(level), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
